// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light safety monitor: light codes,
// fault codes, FSM encoding and direction helpers.
package traffic_pkg;

   localparam int unsigned LIGHT_W = 3;
   localparam int unsigned NUM_DIR = 4;

   localparam logic [LIGHT_W-1:0] GREEN  = 3'b001;
   localparam logic [LIGHT_W-1:0] YELLOW = 3'b010;
   localparam logic [LIGHT_W-1:0] RED    = 3'b100;
   localparam logic [LIGHT_W-1:0] DARK   = 3'b000;

   typedef logic [NUM_DIR-1:0][LIGHT_W-1:0] pattern_t;

   localparam pattern_t ALL_RED_PAT  = {RED, RED, RED, RED};
   localparam pattern_t ALL_DARK_PAT = {DARK, DARK, DARK, DARK};

   localparam logic [2:0] FC_NONE           = 3'd0;
   localparam logic [2:0] FC_CONFLICT       = 3'd1;
   localparam logic [2:0] FC_INVALID        = 3'd2;
   localparam logic [2:0] FC_SKIP_YELLOW    = 3'd3;
   localparam logic [2:0] FC_GREEN_TIMEOUT  = 3'd4;
   localparam logic [2:0] FC_YELLOW_TIMEOUT = 3'd5;
   localparam logic [2:0] FC_ALL_RED        = 3'd6;
   localparam logic [2:0] FC_SEQUENCE       = 3'd7;

   localparam logic [1:0] ST_START      = 2'd0;
   localparam logic [1:0] ST_MONITOR    = 2'd1;
   localparam logic [1:0] ST_FAULT_HOLD = 2'd2;
   localparam logic [1:0] ST_FLASH      = 2'd3;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_N = 2'd0;
   localparam dir_t DIR_S = 2'd1;
   localparam dir_t DIR_E = 2'd2;
   localparam dir_t DIR_W = 2'd3;

   // Green hand-off order N -> S -> E -> W -> N
   function automatic dir_t next_dir(input dir_t d);
      return dir_t'(d + 2'd1);
   endfunction

endpackage

// File: rtl/light_pattern_decode.sv
// Classifies a four-direction lamp pattern: legality, how many directions
// are non-red, which one is active and whether it shows green or yellow.
module light_pattern_decode
   import traffic_pkg::*;
(
   input  logic [LIGHT_W-1:0] north,
   input  logic [LIGHT_W-1:0] south,
   input  logic [LIGHT_W-1:0] east,
   input  logic [LIGHT_W-1:0] west,
   output logic               valid,
   output logic [2:0]         non_red_count,
   output dir_t               active_dir,
   output logic               is_green,
   output logic               is_yellow,
   output logic               all_red
);

   pattern_t codes;

   always_comb begin
      codes        = ALL_RED_PAT;
      codes[DIR_N] = north;
      codes[DIR_S] = south;
      codes[DIR_E] = east;
      codes[DIR_W] = west;
   end

   // Descending scan leaves the lowest-index non-red direction in active_dir
   always_comb begin
      valid         = 1'b1;
      non_red_count = 3'd0;
      active_dir    = DIR_N;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (codes[i] != GREEN && codes[i] != YELLOW && codes[i] != RED)
            valid = 1'b0;
         if (codes[i] != RED) begin
            non_red_count = non_red_count + 3'd1;
            active_dir    = dir_t'(i);
         end
      end
   end

   assign is_green  = (non_red_count == 3'd1) && (codes[active_dir] == GREEN);
   assign is_yellow = (non_red_count == 3'd1) && (codes[active_dir] == YELLOW);
   assign all_red   = (non_red_count == 3'd0);

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety stage between the light sequencer and lamp drivers: passes checked
// patterns through one cycle late, forces all-red then flashing red on a fault.
module traffic_safety_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned MAX_GREEN      = 16,
   parameter int unsigned MAX_YELLOW     = 3,
   parameter int unsigned ALL_RED_CYCLES = 4,
   parameter int unsigned FLASH_HALF     = 2
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [LIGHT_W-1:0] north_light,
   input  logic [LIGHT_W-1:0] south_light,
   input  logic [LIGHT_W-1:0] east_light,
   input  logic [LIGHT_W-1:0] west_light,
   input  logic               clear_fault,
   output logic [LIGHT_W-1:0] lamp_north,
   output logic [LIGHT_W-1:0] lamp_south,
   output logic [LIGHT_W-1:0] lamp_east,
   output logic [LIGHT_W-1:0] lamp_west,
   output logic               fault,
   output logic [2:0]         fault_code,
   output logic [7:0]         fault_count,
   output logic               monitor_active
);

   localparam int unsigned DW = $clog2(MAX_GREEN + 1) + 1;
   localparam int unsigned HW = $clog2(ALL_RED_CYCLES + 1);
   localparam int unsigned FW = $clog2(FLASH_HALF + 1);
   localparam logic [DW-1:0] DWELL_MAX = '1;

   logic [1:0]    state_q, state_d;
   pattern_t      lamps_q, lamps_d;
   pattern_t      prev_q, prev_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [FW-1:0] flash_q, flash_d;
   logic [2:0]    code_q, code_d;
   logic [7:0]    count_q, count_d;
   logic          fault_q, active_q;

   pattern_t cur_pat;
   assign cur_pat = {west_light, east_light, south_light, north_light};

   logic       cur_valid, cur_green, cur_yellow, cur_all_red;
   logic [2:0] cur_non_red;
   dir_t       cur_dir;
   logic       prv_valid, prv_green, prv_yellow, prv_all_red;
   logic [2:0] prv_non_red;
   dir_t       prv_dir;

   light_pattern_decode u_cur_decode (
      .north         (north_light),
      .south         (south_light),
      .east          (east_light),
      .west          (west_light),
      .valid         (cur_valid),
      .non_red_count (cur_non_red),
      .active_dir    (cur_dir),
      .is_green      (cur_green),
      .is_yellow     (cur_yellow),
      .all_red       (cur_all_red)
   );

   light_pattern_decode u_prev_decode (
      .north         (prev_q[DIR_N]),
      .south         (prev_q[DIR_S]),
      .east          (prev_q[DIR_E]),
      .west          (prev_q[DIR_W]),
      .valid         (prv_valid),
      .non_red_count (prv_non_red),
      .active_dir    (prv_dir),
      .is_green      (prv_green),
      .is_yellow     (prv_yellow),
      .all_red       (prv_all_red)
   );

   logic       start_ok, same_pat, prev_single;
   logic       skip_yellow, seq_error, green_timeout, yellow_timeout;
   logic [2:0] fault_sel;

   assign start_ok = (north_light == GREEN) && (south_light == RED) &&
                     (east_light == RED) && (west_light == RED);
   assign same_pat = (cur_pat == prev_q);

   // Transition checks only mean something against a single-lamp prev
   assign prev_single    = prv_valid && (prv_non_red == 3'd1) && !prv_all_red;
   assign skip_yellow    = prev_single && prv_green &&
                           !((cur_green || cur_yellow) && (cur_dir == prv_dir));
   assign seq_error      = prev_single && prv_yellow &&
                           !((cur_yellow && (cur_dir == prv_dir)) ||
                             (cur_green && (cur_dir == next_dir(prv_dir))));
   assign green_timeout  = same_pat && cur_green  && (dwell_q == DW'(MAX_GREEN));
   assign yellow_timeout = same_pat && cur_yellow && (dwell_q == DW'(MAX_YELLOW));

   // Lowest fault code wins
   always_comb begin
      fault_sel = FC_NONE;
      if (cur_non_red > 3'd1)   fault_sel = FC_CONFLICT;
      else if (!cur_valid)      fault_sel = FC_INVALID;
      else if (skip_yellow)     fault_sel = FC_SKIP_YELLOW;
      else if (green_timeout)   fault_sel = FC_GREEN_TIMEOUT;
      else if (yellow_timeout)  fault_sel = FC_YELLOW_TIMEOUT;
      else if (cur_all_red)     fault_sel = FC_ALL_RED;
      else if (seq_error)       fault_sel = FC_SEQUENCE;
   end

   always_comb begin
      state_d = state_q;
      lamps_d = lamps_q;
      prev_d  = prev_q;
      dwell_d = dwell_q;
      hold_d  = hold_q;
      flash_d = flash_q;
      code_d  = code_q;
      count_d = count_q;
      case (state_q)
         ST_START: begin
            lamps_d = ALL_RED_PAT;
            if (start_ok) begin
               state_d = ST_MONITOR;
               lamps_d = cur_pat;
               prev_d  = cur_pat;
               dwell_d = DW'(1);
            end
         end
         ST_MONITOR: begin
            if (fault_sel != FC_NONE) begin
               state_d = ST_FAULT_HOLD;
               lamps_d = ALL_RED_PAT;
               code_d  = fault_sel;
               hold_d  = '0;
               if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else begin
               lamps_d = cur_pat;
               prev_d  = cur_pat;
               if (!same_pat)                dwell_d = DW'(1);
               else if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DW'(1);
            end
         end
         ST_FAULT_HOLD: begin
            lamps_d = ALL_RED_PAT;
            if (hold_q == HW'(ALL_RED_CYCLES - 1)) begin
               state_d = ST_FLASH;
               flash_d = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         ST_FLASH: begin
            if (clear_fault) begin
               state_d = ST_START;
               lamps_d = ALL_RED_PAT;
            end else if (flash_q == FW'(FLASH_HALF - 1)) begin
               flash_d = '0;
               lamps_d = (lamps_q == ALL_RED_PAT) ? ALL_DARK_PAT : ALL_RED_PAT;
            end else begin
               flash_d = flash_q + FW'(1);
            end
         end
         default: begin
            state_d = ST_START;
            lamps_d = ALL_RED_PAT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_START;
         lamps_q  <= ALL_RED_PAT;
         prev_q   <= ALL_RED_PAT;
         dwell_q  <= '0;
         hold_q   <= '0;
         flash_q  <= '0;
         code_q   <= FC_NONE;
         count_q  <= '0;
         fault_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lamps_q  <= lamps_d;
         prev_q   <= prev_d;
         dwell_q  <= dwell_d;
         hold_q   <= hold_d;
         flash_q  <= flash_d;
         code_q   <= code_d;
         count_q  <= count_d;
         fault_q  <= (state_d == ST_FAULT_HOLD) || (state_d == ST_FLASH);
         active_q <= (state_d == ST_MONITOR);
      end
   end

   assign lamp_north     = lamps_q[DIR_N];
   assign lamp_south     = lamps_q[DIR_S];
   assign lamp_east      = lamps_q[DIR_E];
   assign lamp_west      = lamps_q[DIR_W];
   assign fault          = fault_q;
   assign fault_code     = code_q;
   assign fault_count    = count_q;
   assign monitor_active = active_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Directed bench for traffic_safety_monitor: legal rounds, every fault code,
// fault hold / flash timing, clear handling and reset from FLASH.
module tb_traffic_safety_monitor;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;
   localparam logic [11:0] ALLR = {R, R, R, R};

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] north_light, south_light, east_light, west_light;
   logic       clear_fault;
   logic [2:0] lamp_north, lamp_south, lamp_east, lamp_west;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] fault_count;
   logic       monitor_active;

   int tests  = 0;
   int failed = 0;

   traffic_safety_monitor dut (
      .clock          (clock),
      .reset          (reset),
      .north_light    (north_light),
      .south_light    (south_light),
      .east_light     (east_light),
      .west_light     (west_light),
      .clear_fault    (clear_fault),
      .lamp_north     (lamp_north),
      .lamp_south     (lamp_south),
      .lamp_east      (lamp_east),
      .lamp_west      (lamp_west),
      .fault          (fault),
      .fault_code     (fault_code),
      .fault_count    (fault_count),
      .monitor_active (monitor_active)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] pat(input logic [2:0] n, input logic [2:0] s,
                                       input logic [2:0] e, input logic [2:0] w);
      return {w, e, s, n};
   endfunction

   // Legal sequencer pattern for cycle k of a 76-cycle round
   function automatic logic [11:0] legal(input int k);
      logic [11:0] p;
      int ph;
      ph = k / 19;
      p  = ALLR;
      p[ph*3 +: 3] = ((k % 19) < 16) ? G : Y;
      return p;
   endfunction

   task automatic drive(input logic [11:0] p);
      {west_light, east_light, south_light, north_light} = p;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [11:0] lamps();
      return {lamp_west, lamp_east, lamp_south, lamp_north};
   endfunction

   task automatic expect_fault(input string tag, input logic [2:0] code, input logic [7:0] cnt);
      check({tag, "_lamps"}, 32'(lamps()), 32'(ALLR));
      check({tag, "_fault"}, 32'(fault), 32'd1);
      check({tag, "_code"},  32'(fault_code), 32'(code));
      check({tag, "_count"}, 32'(fault_count), 32'(cnt));
      check({tag, "_active"}, 32'(monitor_active), 32'd0);
   endtask

   // Hold clear until the monitor leaves FLASH; bounded
   task automatic recover(input string tag);
      int n;
      n = 0;
      drive(ALLR);
      clear_fault = 1'b1;
      while (fault && n < 20) begin
         tick();
         n++;
      end
      clear_fault = 1'b0;
      check({tag, "_recover"}, 32'(fault), 32'd0);
   endtask

   task automatic enter_monitor(input string tag);
      drive(pat(G, R, R, R));
      tick();
      check({tag, "_enter"}, 32'(monitor_active), 32'd1);
   endtask

   logic [11:0] exp_flash [10];

   initial begin
      reset = 1'b1;
      clear_fault = 1'b0;
      drive(ALLR);
      tick();
      tick();
      check("rst_lamps",  32'(lamps()), 32'(ALLR));
      check("rst_fault",  32'(fault), 32'd0);
      check("rst_code",   32'(fault_code), 32'd0);
      check("rst_count",  32'(fault_count), 32'd0);
      check("rst_active", 32'(monitor_active), 32'd0);
      reset = 1'b0;
      tick();
      check("idle_start", 32'(monitor_active), 32'd0);

      // Two full legal rounds, lamps follow inputs by one cycle
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 76; k++) begin
            drive(legal(k));
            tick();
            check("legal_lamps",  32'(lamps()), 32'(legal(k)));
            check("legal_fault",  32'(fault), 32'd0);
            check("legal_active", 32'(monitor_active), 32'd1);
         end
      end

      // Conflict, then hold / flash timing with clear ignored in FAULT_HOLD
      exp_flash = '{ALLR, ALLR, ALLR, ALLR, ALLR, ALLR, 12'h000, 12'h000, ALLR, ALLR};
      drive(pat(G, R, G, R));
      tick();
      expect_fault("conflict", 3'd1, 8'd1);
      for (int i = 1; i < 10; i++) begin
         if (i == 1) clear_fault = 1'b1;
         if (i == 5) clear_fault = 1'b0;
         tick();
         check($sformatf("flash_lamps_%0d", i), 32'(lamps()), 32'(exp_flash[i]));
         check($sformatf("flash_fault_%0d", i), 32'(fault), 32'd1);
      end
      check("flash_code", 32'(fault_code), 32'd1);

      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("clr_fault",  32'(fault), 32'd0);
      check("clr_code",   32'(fault_code), 32'd1);
      check("clr_lamps",  32'(lamps()), 32'(ALLR));
      check("clr_active", 32'(monitor_active), 32'd0);

      // Skip yellow after 5 green cycles
      enter_monitor("skip");
      drive(pat(G, R, R, R));
      for (int i = 0; i < 4; i++) tick();
      check("skip_pre", 32'(fault), 32'd0);
      drive(pat(R, G, R, R));
      tick();
      expect_fault("skip", 3'd3, 8'd2);

      // Green timeout: 16 green cycles legal, 17th faults
      recover("gto");
      enter_monitor("gto");
      for (int i = 0; i < 15; i++) tick();
      check("gto_16_ok", 32'(fault), 32'd0);
      tick();
      expect_fault("gto", 3'd4, 8'd3);

      // Yellow timeout: 3 yellow cycles legal, 4th faults
      recover("yto");
      enter_monitor("yto");
      drive(pat(Y, R, R, R));
      for (int i = 0; i < 3; i++) tick();
      check("yto_3_ok", 32'(fault), 32'd0);
      tick();
      expect_fault("yto", 3'd5, 8'd4);

      // Yellow N followed by green E
      recover("seq");
      enter_monitor("seq");
      drive(pat(Y, R, R, R));
      tick();
      drive(pat(R, R, G, R));
      tick();
      expect_fault("seq", 3'd7, 8'd5);

      // All red after yellow: all-red outranks sequence
      recover("allred");
      enter_monitor("allred");
      drive(pat(Y, R, R, R));
      tick();
      drive(ALLR);
      tick();
      expect_fault("allred", 3'd6, 8'd6);

      // Invalid code 011 on north
      recover("inv");
      enter_monitor("inv");
      drive(pat(3'b011, R, R, R));
      tick();
      expect_fault("inv", 3'd2, 8'd7);

      // Reach FLASH, then reset
      for (int i = 0; i < 6; i++) tick();
      check("pre_rst_fault", 32'(fault), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_lamps",  32'(lamps()), 32'(ALLR));
      check("mid_rst_fault",  32'(fault), 32'd0);
      check("mid_rst_code",   32'(fault_code), 32'd0);
      check("mid_rst_count",  32'(fault_count), 32'd0);
      check("mid_rst_active", 32'(monitor_active), 32'd0);
      reset = 1'b0;

      // Unknown inputs and near-miss patterns keep START
      {west_light, east_light, south_light, north_light} = 'x;
      for (int i = 0; i < 3; i++) tick();
      drive(pat(G, R, Y, R));
      tick();
      check("x_active", 32'(monitor_active), 32'd0);
      check("x_fault",  32'(fault), 32'd0);
      check("x_lamps",  32'(lamps()), 32'(ALLR));
      enter_monitor("post_rst");
      check("post_rst_lamps", 32'(lamps()), 32'(pat(G, R, R, R)));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
